// File: rtl/gate_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package gate_fetch_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;
   localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD
   } fetch_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] word;
      logic [ADDR_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Shift-style instruction FIFO: entry 0 is always the head, and it keeps its
// last value when the queue drains or is flushed.
module fetch_queue
   import gate_fetch_pkg::*;
#(
   parameter  int unsigned QDEPTH = 2,
   localparam int unsigned CNT_W  = $clog2(QDEPTH + 1),
   localparam int unsigned IDX_W  = $clog2(QDEPTH)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  fetch_entry_t     push_entry_i,
   input  logic             pop_i,
   output logic [CNT_W-1:0] occupancy_o,
   output fetch_entry_t     head_o
);

   fetch_entry_t     entries_q [QDEPTH];
   logic [CNT_W-1:0] count_q;
   logic [IDX_W-1:0] wr_idx_c;

   // A simultaneous pop frees the slot below the current tail.
   always_comb begin
      wr_idx_c = IDX_W'(count_q - CNT_W'(pop_i));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
         for (int i = 0; i < int'(QDEPTH); i++) begin
            entries_q[i] <= '0;
         end
      end else if (flush_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
         if (pop_i) begin
            for (int i = 0; i < int'(QDEPTH) - 1; i++) begin
               if (CNT_W'(i + 1) < count_q) begin
                  entries_q[i] <= entries_q[i+1];
               end
            end
         end
         if (push_i) begin
            entries_q[wr_idx_c] <= push_entry_i;
         end
      end
   end

   assign occupancy_o = count_q;
   assign head_o      = entries_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, memory read issue, return capture and decode
// handshake. Optional FETCH_PERF_EN adds fetched/stall counters.
module fetch_unit
   import gate_fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
   parameter int unsigned       QDEPTH   = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_q,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]       perf_fetched,
   output logic [15:0]       perf_stall
`endif
);

   localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] pc_pipe_q, pc_pipe_d;
   logic              inflight_q, inflight_d;
   logic              squash_q, squash_d;

   logic [CNT_W-1:0]  occupancy;
   fetch_entry_t      head;
   fetch_entry_t      ret_entry;
   logic              pop_c, push_c, room_c, issue_c;
   logic [SUM_W-1:0]  demand_c;

   // Slots already claimed after this cycle's pop; a new issue needs one free.
   always_comb begin
      pop_c    = instr_valid & instr_ready & ~redirect_valid;
      push_c   = inflight_q & ~squash_q & ~redirect_valid;
      demand_c = SUM_W'(occupancy) + SUM_W'(inflight_q) - SUM_W'(pop_c);
      room_c   = demand_c < SUM_W'(QDEPTH);
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pc_pipe_d  = pc_pipe_q;
      inflight_d = 1'b0;
      squash_d   = 1'b0;
      issue_c    = 1'b0;
      case (state_q)
         IDLE: state_d = FETCH;
         // HOLD issues again in the very cycle a slot reopens.
         FETCH, HOLD: begin
            issue_c = room_c & ~redirect_valid & ~reset;
            state_d = room_c ? FETCH : HOLD;
         end
         default: state_d = IDLE;
      endcase
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         squash_d   = inflight_q;
         state_d    = FETCH;
      end else if (issue_c) begin
         fetch_pc_d = fetch_pc_q + ADDR_W'(1);
         pc_pipe_d  = fetch_pc_q;
         inflight_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         pc_pipe_q  <= '0;
         inflight_q <= 1'b0;
         squash_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pc_pipe_q  <= pc_pipe_d;
         inflight_q <= inflight_d;
         squash_q   <= squash_d;
      end
   end

   assign ret_entry = '{word: mem_q, pc: pc_pipe_q};

   fetch_queue #(
      .QDEPTH(QDEPTH)
   ) u_queue (
      .clk_i        (clk),
      .reset_i      (reset),
      .flush_i      (redirect_valid),
      .push_i       (push_c),
      .push_entry_i (ret_entry),
      .pop_i        (pop_c),
      .occupancy_o  (occupancy),
      .head_o       (head)
   );

   assign mem_addr    = fetch_pc_q;
   assign mem_re      = issue_c;
   assign instr_valid = (occupancy != '0);
   assign instr       = head.word;
   assign instr_pc    = head.pc;

`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched_q, perf_stall_q;
   logic        stall_c;

   always_comb begin
      stall_c = (state_q != IDLE) & ~room_c & ~redirect_valid & ~instr_valid;
   end

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         if (push_c && perf_fetched_q != 16'hFFFF) begin
            perf_fetched_q <= perf_fetched_q + 16'd1;
         end
         if (stall_c && perf_stall_q != 16'hFFFF) begin
            perf_stall_q <= perf_stall_q + 16'd1;
         end
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: program-order model of delivered (pc, word) pairs
// plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset, redirect_valid, instr_ready;
   logic        mem_re, instr_valid;
   logic [15:0] mem_addr, mem_q, redirect_pc, instr, instr_pc;

   logic [15:0] mem [0:65535];
   int          tests = 0;
   int          fails = 0;
   bit          checking = 1'b0;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC (16'h0000),
      .QDEPTH   (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_addr       (mem_addr),
      .mem_re         (mem_re),
      .mem_q          (mem_q),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc)
   );

   // Synchronous-read memory, one cycle latency.
   always @(posedge clk) mem_q <= mem[mem_addr];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Program-order model: every accepted word must be the next sequential pc
   // since the last reset/redirect, carrying that address's memory contents.
   logic [15:0] exp_pc;
   bit          expect_empty = 1'b0;
   bit          prev_stall = 1'b0;
   logic [15:0] prev_pc, prev_instr;

   always @(negedge clk) begin
      if (checking) begin
         if (expect_empty) check("empty_after_flush", 32'(instr_valid), 32'd0);
         if (prev_stall) begin
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc", 32'(instr_pc), 32'(prev_pc));
            check("stall_instr", 32'(instr), 32'(prev_instr));
         end
         if (instr_valid && instr_ready && !reset && !redirect_valid) begin
            check("order_pc", 32'(instr_pc), 32'(exp_pc));
            check("order_instr", 32'(instr), 32'(mem[exp_pc]));
            exp_pc = exp_pc + 16'd1;
         end
         expect_empty = reset | redirect_valid;
         prev_stall   = instr_valid & ~instr_ready & ~reset & ~redirect_valid;
         prev_pc      = instr_pc;
         prev_instr   = instr;
         if (reset) exp_pc = 16'h0000;
         else if (redirect_valid) exp_pc = redirect_pc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic wait_valid(input string name, input int budget, output int waited);
      bit ok = 1'b0;
      waited = 0;
      for (int i = 0; i < budget; i++) begin
         if (instr_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
         waited++;
      end
      check(name, 32'(ok), 32'd1);
   endtask

   initial begin
      int          waited;
      logic [15:0] pat;
      for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A00;
      mem[16'h0000] = 16'h1111;
      mem[16'h0001] = 16'h2222;
      mem[16'h0002] = 16'h3333;
      mem[16'h0003] = 16'h4444;
      mem[16'h0010] = 16'hC010;
      mem[16'hFFFF] = 16'h0073;
      exp_pc         = 16'h0000;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      instr_ready    = 1'b0;
      repeat (3) tick();

      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", 32'(instr), 32'd0);
      check("rst_pc", 32'(instr_pc), 32'd0);
      check("rst_re", 32'(mem_re), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'h0000);

      // Cycle 0 after release is the idle cycle.
      reset = 1'b0; instr_ready = 1'b1; checking = 1'b1;
      settle();
      check("idle_re", 32'(mem_re), 32'd0);
      tick();
      check("first_issue_re", 32'(mem_re), 32'd1);
      check("first_issue_addr", 32'(mem_addr), 32'h0000);
      tick();
      check("c2_valid", 32'(instr_valid), 32'd0);
      tick();
      check("c3_valid", 32'(instr_valid), 32'd1);
      check("c3_pc", 32'(instr_pc), 32'h0000);
      check("c3_instr", 32'(instr), 32'h1111);
      tick();
      check("c4_pc", 32'(instr_pc), 32'h0001);
      check("c4_instr", 32'(instr), 32'h2222);
      tick();
      check("c5_pc", 32'(instr_pc), 32'h0002);
      tick();
      check("c6_instr", 32'(instr), 32'h4444);

      // Restart at 0 with decode stalled: queue fills, fetch holds.
      redirect_valid = 1'b1; redirect_pc = 16'h0000; instr_ready = 1'b0;
      tick();
      redirect_valid = 1'b0;
      settle();
      check("redir0_re", 32'(mem_re), 32'd1);
      check("redir0_addr", 32'(mem_addr), 32'h0000);
      repeat (6) tick();
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_pc", 32'(instr_pc), 32'h0000);
      check("hold_instr", 32'(instr), 32'h1111);
      check("hold_re", 32'(mem_re), 32'd0);
      check("hold_addr", 32'(mem_addr), 32'h0002);

      instr_ready = 1'b1;
      settle();
      check("release_re", 32'(mem_re), 32'd1);
      tick();
      check("release_pc1", 32'(instr_pc), 32'h0001);

      // Redirect while the word for 0x0002 is returning.
      redirect_valid = 1'b1; redirect_pc = 16'h0010;
      tick();
      redirect_valid = 1'b0;
      settle();
      check("redir10_addr", 32'(mem_addr), 32'h0010);
      check("redir10_re", 32'(mem_re), 32'd1);
      wait_valid("redir10_timeout", 5, waited);
      check("redir10_latency", 32'(waited), 32'd2);
      check("redir10_pc", 32'(instr_pc), 32'h0010);
      check("redir10_instr", 32'(instr), 32'hC010);

      // Wrap through the top of the address space.
      redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
      tick();
      redirect_valid = 1'b0;
      wait_valid("wrap_timeout", 5, waited);
      check("wrap_pc0", 32'(instr_pc), 32'hFFFE);
      check("wrap_instr0", 32'(instr), 32'hA5FE);
      tick();
      check("wrap_pc1", 32'(instr_pc), 32'hFFFF);
      check("wrap_instr1", 32'(instr), 32'h0073);
      tick();
      check("wrap_pc2", 32'(instr_pc), 32'h0000);
      check("wrap_instr2", 32'(instr), 32'h1111);
      tick();

      // One-cycle reset while streaming with a word in flight.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      settle();
      check("mid_rst_valid", 32'(instr_valid), 32'd0);
      check("mid_rst_addr", 32'(mem_addr), 32'h0000);
      check("mid_rst_re", 32'(mem_re), 32'd0);
      wait_valid("mid_rst_timeout", 6, waited);
      check("mid_rst_pc", 32'(instr_pc), 32'h0000);
      check("mid_rst_instr", 32'(instr), 32'h1111);

      // Irregular decode back-pressure; ordering and stability via the model.
      redirect_valid = 1'b1; redirect_pc = 16'h0100;
      tick();
      redirect_valid = 1'b0;
      pat = 16'b1011_0011_1000_1101;
      for (int i = 0; i < 40; i++) begin
         instr_ready = pat[i % 16];
         tick();
      end
      instr_ready = 1'b1;
      repeat (4) tick();
      check("stream_pc_advanced", 32'(exp_pc > 16'h0100), 32'd1);

      checking = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
